// File: rtl/miriscv_bus_pkg.sv
// Shared types and default address map for the miriscv data-side interconnect.
package miriscv_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2,
    ERR  = 2'd3
  } bus_state_t;

  localparam int unsigned ERR_CNT_W    = 8;
  localparam int unsigned DEF_N_SLAVES = 4;

  // Index 0 is the leftmost entry so the literal lists slaves in ascending order.
  localparam logic [0:DEF_N_SLAVES-1][31:0] DEF_SLAVE_BASE =
    {32'h0000_0000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000};
  localparam logic [0:DEF_N_SLAVES-1][31:0] DEF_SLAVE_MASK = {4{32'hFFFF_0000}};

  // Slave index width; a single slave still needs a 1-bit select.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/miriscv_addr_decoder.sv
// Priority base/mask address decoder: lowest matching slave index wins.
module miriscv_addr_decoder
  import miriscv_bus_pkg::*;
#(
  parameter int unsigned N_SLAVES = DEF_N_SLAVES,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned SEL_W    = sel_width(N_SLAVES),
  parameter logic [0:N_SLAVES-1][ADDR_W-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [0:N_SLAVES-1][ADDR_W-1:0] SLAVE_MASK = DEF_SLAVE_MASK
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit_c,
  output logic [SEL_W-1:0]  sel_c,
  output logic [ADDR_W-1:0] offset_c
);

  // Scan from the top so the lowest hitting index is the last one written.
  always_comb begin
    hit_c    = 1'b0;
    sel_c    = '0;
    offset_c = '0;
    for (int k = int'(N_SLAVES) - 1; k >= 0; k--) begin
      if ((addr & SLAVE_MASK[k]) == SLAVE_BASE[k]) begin
        hit_c    = 1'b1;
        sel_c    = SEL_W'(k);
        offset_c = addr & ~SLAVE_MASK[k];
      end
    end
  end

endmodule

// File: rtl/miriscv_data_bus.sv
// Data-side interconnect: LSU port to N memory-mapped slaves with one
// outstanding transaction, timeout and bus-error responses.
module miriscv_data_bus
  import miriscv_bus_pkg::*;
#(
  parameter int unsigned N_SLAVES       = DEF_N_SLAVES,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter logic [0:N_SLAVES-1][ADDR_W-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
  parameter logic [0:N_SLAVES-1][ADDR_W-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                         clk_i,
  input  logic                         arstn_i,
  input  logic                         m_req_i,
  input  logic                         m_we_i,
  input  logic [DATA_W/8-1:0]          m_be_i,
  input  logic [ADDR_W-1:0]            m_addr_i,
  input  logic [DATA_W-1:0]            m_wdata_i,
  output logic                         m_stall_o,
  output logic                         m_rvalid_o,
  output logic [DATA_W-1:0]            m_rdata_o,
  output logic                         m_err_o,
  output logic [ERR_CNT_W-1:0]         err_cnt_o,
  output logic [N_SLAVES-1:0]          s_req_o,
  output logic                         s_we_o,
  output logic [DATA_W/8-1:0]          s_be_o,
  output logic [ADDR_W-1:0]            s_addr_o,
  output logic [DATA_W-1:0]            s_wdata_o,
  input  logic [N_SLAVES-1:0]          s_gnt_i,
  input  logic [N_SLAVES-1:0]          s_rvalid_i,
  input  logic [N_SLAVES*DATA_W-1:0]   s_rdata_i
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned SEL_W = sel_width(N_SLAVES);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  bus_state_t           state_q, state_d;
  logic [SEL_W-1:0]     sel_q, sel_d;
  logic                 we_q, we_d;
  logic [BE_W-1:0]      be_q, be_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_SLAVES-1:0]  s_req_q, s_req_d;
  logic                 m_rvalid_q, m_rvalid_d;
  logic                 m_err_q, m_err_d;
  logic [DATA_W-1:0]    m_rdata_q, m_rdata_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 dec_hit;
  logic [SEL_W-1:0]     dec_sel;
  logic [ADDR_W-1:0]    dec_offset;
  logic                 gnt_sel, rvalid_sel, timeout;
  logic [DATA_W-1:0]    rdata_sel;

  miriscv_addr_decoder #(
    .N_SLAVES   (N_SLAVES),
    .ADDR_W     (ADDR_W),
    .SEL_W      (SEL_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decoder (
    .addr     (m_addr_i),
    .hit_c    (dec_hit),
    .sel_c    (dec_sel),
    .offset_c (dec_offset)
  );

  assign gnt_sel    = s_gnt_i[sel_q];
  assign rvalid_sel = s_rvalid_i[sel_q];
  assign rdata_sel  = s_rdata_i[int'(sel_q)*DATA_W +: DATA_W];
  // Fires on the TIMEOUT_CYCLES-th cycle spent in ADDR+RESP.
  assign timeout    = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and next-output logic; responses and slave requests are one-cycle unless held.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    err_cnt_d  = err_cnt_q;
    s_req_d    = '0;
    m_rvalid_d = 1'b0;
    m_err_d    = 1'b0;
    m_rdata_d  = '0;
    case (state_q)
      IDLE: begin
        if (m_req_i && !m_rvalid_q) begin
          sel_d   = dec_sel;
          we_d    = m_we_i;
          be_d    = m_be_i;
          addr_d  = dec_offset;
          wdata_d = m_wdata_i;
          cnt_d   = '0;
          if (dec_hit) begin
            state_d = ADDR;
            s_req_d = N_SLAVES'(1) << dec_sel;
          end else begin
            state_d = ERR;
          end
        end
      end
      ADDR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (gnt_sel) begin
          state_d = RESP;
        end else if (timeout) begin
          state_d = ERR;
        end else begin
          s_req_d = s_req_q;
        end
      end
      RESP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (rvalid_sel) begin
          state_d    = IDLE;
          m_rvalid_d = 1'b1;
          m_rdata_d  = we_q ? '0 : rdata_sel;
        end else if (timeout) begin
          state_d = ERR;
        end
      end
      ERR: begin
        state_d    = IDLE;
        m_rvalid_d = 1'b1;
        m_err_d    = 1'b1;
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= IDLE;
      sel_q      <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      err_cnt_q  <= '0;
      s_req_q    <= '0;
      m_rvalid_q <= 1'b0;
      m_err_q    <= 1'b0;
      m_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      s_req_q    <= s_req_d;
      m_rvalid_q <= m_rvalid_d;
      m_err_q    <= m_err_d;
      m_rdata_q  <= m_rdata_d;
    end
  end

  // Stall follows the request combinationally so the core freezes in the accept cycle.
  assign m_stall_o  = (m_req_i | (state_q != IDLE)) & ~m_rvalid_q;
  assign m_rvalid_o = m_rvalid_q;
  assign m_err_o    = m_err_q;
  assign m_rdata_o  = m_rdata_q;
  assign err_cnt_o  = err_cnt_q;
  assign s_req_o    = s_req_q;
  assign s_we_o     = we_q;
  assign s_be_o     = be_q;
  assign s_addr_o   = addr_q;
  assign s_wdata_o  = wdata_q;

endmodule

// File: tb/tb_miriscv_data_bus.sv
// Directed testbench for miriscv_data_bus with a response scoreboard.
module tb_miriscv_data_bus;

  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = DW / 8;
  localparam int unsigned TO  = 16;
  // Slave 1 covers 0x0_0000-0x1_FFFF, overlapping slave 0 at the bottom 64K.
  localparam logic [0:N-1][AW-1:0] BASE =
    {32'h0000_0000, 32'h0000_0000, 32'h0002_0000, 32'h0003_0000};
  localparam logic [0:N-1][AW-1:0] MASK =
    {32'hFFFF_0000, 32'hFFFE_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } resp_t;

  logic              clk, arstn;
  logic              m_req, m_we;
  logic [BEW-1:0]    m_be;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_wdata;
  logic              m_stall, m_rvalid, m_err;
  logic [DW-1:0]     m_rdata;
  logic [7:0]        err_cnt;
  logic [N-1:0]      s_req, s_gnt, s_rvalid;
  logic              s_we;
  logic [BEW-1:0]    s_be;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [N*DW-1:0]   s_rdata;

  resp_t sb[$];
  resp_t mon_exp;
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    c0;

  miriscv_data_bus #(
    .N_SLAVES(N), .ADDR_W(AW), .DATA_W(DW),
    .SLAVE_BASE(BASE), .SLAVE_MASK(MASK), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i(clk), .arstn_i(arstn),
    .m_req_i(m_req), .m_we_i(m_we), .m_be_i(m_be), .m_addr_i(m_addr), .m_wdata_i(m_wdata),
    .m_stall_o(m_stall), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .m_err_o(m_err),
    .err_cnt_o(err_cnt),
    .s_req_o(s_req), .s_we_o(s_we), .s_be_o(s_be), .s_addr_o(s_addr), .s_wdata_o(s_wdata),
    .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [BEW-1:0] be, input logic [AW-1:0] addr,
                     input logic [DW-1:0] wdata);
    m_req = 1'b1; m_we = we; m_be = be; m_addr = addr; m_wdata = wdata;
  endtask

  task automatic set_rdata(input int k, input logic [DW-1:0] v);
    s_rdata[k*DW +: DW] = v;
  endtask

  task automatic wait_rv(input string tag, input int bound);
    logic found;
    found = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (m_rvalid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, 64'(found), 64'd1);
  endtask

  // Every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (m_rvalid === 1'b1) begin
      chk("rvalid_expected", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        mon_exp = sb.pop_front();
        chk("m_err", 64'(m_err), 64'(mon_exp.err));
        chk("m_rdata", 64'(m_rdata), 64'(mon_exp.rdata));
      end
    end
  end

  initial begin
    arstn = 1'b0; m_req = 1'b0; m_we = 1'b0; m_be = '0; m_addr = '0; m_wdata = '0;
    s_gnt = '0; s_rvalid = '0; s_rdata = '0;
    step(); step();
    chk("rst_s_req", 64'(s_req), 64'd0);
    chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_stall", 64'(m_stall), 64'd0);
    arstn = 1'b1;
    step();

    // Read slave 0 at 0x10, minimum latency.
    req(1'b0, 4'hF, 32'h0000_0010, 32'h0);
    sb.push_back('{err: 1'b0, rdata: 32'hDEAD_BEEF});
    #1 chk("t1_stall_T0", 64'(m_stall), 64'd1);
    step();
    chk("t1_s_req", 64'(s_req), 64'b0001);
    chk("t1_s_addr", 64'(s_addr), 64'h10);
    chk("t1_s_we", 64'(s_we), 64'd0);
    chk("t1_stall_T1", 64'(m_stall), 64'd1);
    s_gnt = 4'b0001;
    step();
    s_gnt = '0;
    chk("t1_s_req_drop", 64'(s_req), 64'd0);
    chk("t1_stall_T2", 64'(m_stall), 64'd1);
    s_rvalid = 4'b0001; set_rdata(0, 32'hDEAD_BEEF); set_rdata(3, 32'h1111_2222);
    step();
    s_rvalid = '0;
    chk("t1_rvalid_T3", 64'(m_rvalid), 64'd1);
    // Back-to-back write to slave 2, held through the response cycle.
    req(1'b1, 4'b0011, 32'h0002_0004, 32'h0000_1234);
    sb.push_back('{err: 1'b0, rdata: 32'h0});
    #1 chk("t1_stall_T3", 64'(m_stall), 64'd0);
    step();
    chk("t2_no_accept_on_rvalid", 64'(s_req), 64'd0);
    chk("t2_stall", 64'(m_stall), 64'd1);
    step();
    chk("t2_s_req", 64'(s_req), 64'b0100);
    chk("t2_s_we", 64'(s_we), 64'd1);
    chk("t2_s_be", 64'(s_be), 64'b0011);
    chk("t2_s_addr", 64'(s_addr), 64'h4);
    chk("t2_s_wdata", 64'(s_wdata), 64'h1234);
    s_gnt = 4'b0100; s_rvalid = 4'b0100; set_rdata(2, 32'hFFFF_FFFF);
    step();
    s_gnt = '0;
    chk("t2_gnt_only_taken", 64'(m_rvalid), 64'd0);
    chk("t2_s_req_drop", 64'(s_req), 64'd0);
    step();
    s_rvalid = '0;
    chk("t2_rvalid", 64'(m_rvalid), 64'd1);
    m_req = 1'b0;
    step();

    // Unmapped read, then saturate the error counter.
    chk("t3_err_cnt0", 64'(err_cnt), 64'd0);
    req(1'b0, 4'hF, 32'h0009_0000, 32'h0);
    sb.push_back('{err: 1'b1, rdata: 32'h0});
    step();
    chk("t3_no_s_req", 64'(s_req), 64'd0);
    chk("t3_stall_err", 64'(m_stall), 64'd1);
    step();
    chk("t3_rvalid_T2", 64'(m_rvalid), 64'd1);
    chk("t3_err_cnt1", 64'(err_cnt), 64'd1);
    for (int i = 0; i < 255; i++) begin
      sb.push_back('{err: 1'b1, rdata: 32'h0});
      wait_rv("t3_err_loop", 10);
      if (i == 98) chk("t3_err_cnt100", 64'(err_cnt), 64'd100);
    end
    m_req = 1'b0;
    chk("t3_err_cnt_sat", 64'(err_cnt), 64'd255);
    step();

    // Slave 1 grants but never responds: timeout error.
    req(1'b0, 4'hF, 32'h0001_0008, 32'h0);
    sb.push_back('{err: 1'b1, rdata: 32'h0});
    c0 = cyc;
    step();
    chk("t4_s_req", 64'(s_req), 64'b0010);
    chk("t4_s_addr", 64'(s_addr), 64'h1_0008);
    s_gnt = 4'b0010;
    step();
    s_gnt = '0;
    wait_rv("t4_timeout_seen", 40);
    chk("t4_timeout_latency", 64'(cyc - c0), 64'(TO + 2));
    chk("t4_err_cnt_hold", 64'(err_cnt), 64'd255);
    m_req = 1'b0;
    step();
    s_rvalid = 4'b0010; set_rdata(1, 32'h7777_7777);
    step();
    s_rvalid = '0;
    chk("t4_late_rvalid_a", 64'(m_rvalid), 64'd0);
    step();
    chk("t4_late_rvalid_b", 64'(m_rvalid), 64'd0);

    // Overlap at 0x0 resolves to slave 0; stray responses are ignored.
    req(1'b0, 4'hF, 32'h0000_0000, 32'h0);
    sb.push_back('{err: 1'b0, rdata: 32'hCAFE_F00D});
    step();
    chk("t5_s_req", 64'(s_req), 64'b0001);
    s_gnt = 4'b0011;
    step();
    s_gnt = '0;
    s_rvalid = 4'b1000; set_rdata(3, 32'h0BAD_0BAD);
    step();
    chk("t5_stray_ignored", 64'(m_rvalid), 64'd0);
    s_rvalid = 4'b0001; set_rdata(0, 32'hCAFE_F00D);
    step();
    s_rvalid = '0;
    chk("t5_rvalid", 64'(m_rvalid), 64'd1);
    m_req = 1'b0;
    step();

    // Reset while in RESP abandons the transaction.
    req(1'b0, 4'hF, 32'h0003_0020, 32'h0);
    step();
    chk("t6_s_req", 64'(s_req), 64'b1000);
    chk("t6_s_addr", 64'(s_addr), 64'h20);
    s_gnt = 4'b1000;
    step();
    s_gnt = '0;
    arstn = 1'b0; m_req = 1'b0; s_rvalid = 4'b1000;
    #1;
    chk("t6_rst_s_req", 64'(s_req), 64'd0);
    chk("t6_rst_rvalid", 64'(m_rvalid), 64'd0);
    chk("t6_rst_err", 64'(m_err), 64'd0);
    chk("t6_rst_rdata", 64'(m_rdata), 64'd0);
    chk("t6_rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("t6_rst_stall", 64'(m_stall), 64'd0);
    chk("t6_rst_s_addr", 64'(s_addr), 64'd0);
    step(); step();
    s_rvalid = '0;
    arstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_no_spurious", 64'(m_rvalid), 64'd0);
    end
    req(1'b0, 4'hF, 32'h0003_0020, 32'h0);
    sb.push_back('{err: 1'b0, rdata: 32'h55AA_55AA});
    step();
    s_gnt = 4'b1000;
    step();
    s_gnt = '0;
    s_rvalid = 4'b1000; set_rdata(3, 32'h55AA_55AA);
    step();
    s_rvalid = '0;
    chk("t6_rvalid_after_rst", 64'(m_rvalid), 64'd1);
    m_req = 1'b0;
    step(); step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
